div_unit: RTL



---
 rtl/div_unit.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit : iterative RV32M divider (DIV, DIVU, REM, REMU)
//
// Radix-2 restoring divider, one quotient bit per clock. Operands are turned
// into magnitudes at accept time, and the recorded signs are applied in a
// final FIX cycle. Divide-by-zero and signed overflow finish in one cycle.
//
// Optional build macro:
//   DIV_REUSE_EN - keeps a single-entry cache of the last completed division
//                  (operands, signedness, quotient and remainder). A DIV
//                  followed by a REM on the same operands, or the reverse,
//                  then completes in one cycle.
//
// Latency: 1 cycle for special cases and cache hits, 34 cycles otherwise.
// ---------------------------------------------------------------------------
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic [1:0]      i_func,
    input  logic [XLEN-1:0] i_dividend,
    input  logic [XLEN-1:0] i_divisor,
    input  logic            i_flush,
    output logic            o_busy,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);

    // Most negative signed value; the only dividend that can overflow DIV.
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    // Counter value in the cycle that produces the last quotient bit.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN-1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t            r_state;
    logic              r_busy;
    logic              r_done;
    logic [XLEN-1:0]   r_result;
    logic [CNT_W-1:0]  r_cnt;
    logic [XLEN-1:0]   r_rem;       // partial remainder
    logic [XLEN-1:0]   r_quot;      // dividend bits shifting out, quotient shifting in
    logic [XLEN-1:0]   r_divisor;   // divisor magnitude
    logic              r_sel_rem;   // 1: return remainder, 0: return quotient
    logic              r_q_neg;     // quotient must be negated in FIX
    logic              r_r_neg;     // remainder must be negated in FIX

    // ------------------------------------------------------------------
    // Operand conditioning at accept time
    // ------------------------------------------------------------------
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_res;
    logic              w_can_accept;
    logic              w_take_fast;
    logic              w_take_run;

    assign w_signed = ~i_func[0];
    assign w_a_neg  = w_signed & i_dividend[XLEN-1];
    assign w_b_neg  = w_signed & i_divisor[XLEN-1];
    assign w_a_abs  = w_a_neg ? -i_dividend : i_dividend;
    assign w_b_abs  = w_b_neg ? -i_divisor  : i_divisor;

    // Detect the two operand patterns whose results are fixed by the ISA
    always_comb begin
        // NOTE: every output of an always_comb gets a default first so that
        // no path leaves it unassigned, which would infer a latch.
        w_special     = 1'b0;
        w_special_res = '0;
        if (i_divisor == '0) begin
            w_special     = 1'b1;
            w_special_res = i_func[1] ? i_dividend : '1;
        end else if (w_signed && (i_dividend == MIN_NEG) && (i_divisor == '1)) begin
            w_special     = 1'b1;
            w_special_res = i_func[1] ? '0 : MIN_NEG;
        end
    end

    assign w_can_accept = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_take_fast  = i_start & w_can_accept & (w_special | w_hit);
    assign w_take_run   = i_start & w_can_accept & ~w_special & ~w_hit;

    // ------------------------------------------------------------------
    // Datapath: restoring iteration and final sign correction
    // ------------------------------------------------------------------
    logic [XLEN-1:0]   w_shift;     // low XLEN bits of the shifted remainder
    logic [XLEN:0]     w_diff;      // 33-bit trial difference
    logic              w_ge;        // trial difference is non-negative
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;

    assign w_shift = {r_rem[XLEN-2:0], r_quot[XLEN-1]};
    assign w_diff  = {r_rem[XLEN-1], w_shift} - {1'b0, r_divisor};
    assign w_ge    = ~w_diff[XLEN];
    assign w_q_fix = r_q_neg ? -r_quot : r_quot;
    assign w_r_fix = r_r_neg ? -r_rem  : r_rem;

    // ------------------------------------------------------------------
    // Optional result cache
    // ------------------------------------------------------------------
`ifdef DIV_REUSE_EN
    logic              r_op_uns;    // signedness of the operation in flight
    logic [XLEN-1:0]   r_op_a;      // raw operands of the operation in flight
    logic [XLEN-1:0]   r_op_b;
    logic              r_c_valid;
    logic              r_c_uns;
    logic [XLEN-1:0]   r_c_a;
    logic [XLEN-1:0]   r_c_b;
    logic [XLEN-1:0]   r_c_quot;
    logic [XLEN-1:0]   r_c_rem;

    assign w_hit     = r_c_valid && (r_c_a == i_dividend) && (r_c_b == i_divisor)
                       && (r_c_uns == i_func[0]);
    assign w_hit_res = i_func[1] ? r_c_rem : r_c_quot;

    // Capture raw operands on accept and fill the cache when an op completes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            // NOTE: the cache contents are reset along with the valid bit;
            // only r_c_valid matters functionally, but clearing everything
            // keeps post-reset state fully deterministic.
            r_op_uns  <= 1'b0;
            r_op_a    <= '0;
            r_op_b    <= '0;
            r_c_valid <= 1'b0;
            r_c_uns   <= 1'b0;
            r_c_a     <= '0;
            r_c_b     <= '0;
            r_c_quot  <= '0;
            r_c_rem   <= '0;
        end else if (i_flush) begin
            r_c_valid <= 1'b0;
        end else begin
            if (w_take_run) begin
                r_op_uns <= i_func[0];
                r_op_a   <= i_dividend;
                r_op_b   <= i_divisor;
            end
            if (r_state == S_FIX) begin
                r_c_valid <= 1'b1;
                r_c_uns   <= r_op_uns;
                r_c_a     <= r_op_a;
                r_c_b     <= r_op_b;
                r_c_quot  <= w_q_fix;
                r_c_rem   <= w_r_fix;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    // ------------------------------------------------------------------
    // Control FSM with registered BUSY/DONE/RESULT
    // ------------------------------------------------------------------
    // Sequence IDLE -> RUN (32 iterations) -> FIX -> DONE, with 1-cycle paths
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quot    <= '0;
            r_divisor <= '0;
            r_sel_rem <= 1'b0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
        end else if (i_flush) begin
            // Pipeline kill: drop the operation and any START at this edge;
            // RESULT keeps the last completed value.
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    // NOTE: state registers use non-blocking assignments so
                    // every register samples pre-edge values, independent of
                    // statement order.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    if (w_take_fast) begin
                        r_state  <= S_DONE;
                        r_done   <= 1'b1;
                        r_result <= w_special ? w_special_res : w_hit_res;
                    end else if (w_take_run) begin
                        r_state   <= S_RUN;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_rem     <= '0;
                        r_quot    <= w_a_abs;
                        r_divisor <= w_b_abs;
                        r_sel_rem <= i_func[1];
                        r_q_neg   <= w_a_neg ^ w_b_neg;
                        r_r_neg   <= w_a_neg;
                    end
                end

                S_RUN: begin
                    r_rem  <= w_ge ? w_diff[XLEN-1:0] : w_shift;
                    r_quot <= {r_quot[XLEN-2:0], w_ge};
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= S_FIX;
                    end
                end

                S_FIX: begin
                    r_result <= r_sel_rem ? w_r_fix : w_q_fix;
                    r_state  <= S_DONE;
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                end

                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_result = r_result;

endmodule
